// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and default widths for the instruction fetch unit.
// Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int c_PC_W    = 16;
    localparam int c_INSTR_W = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [c_PC_W-1:0]    pc;
        logic [c_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Fall-through prefetch FIFO of fetch entries, wrap-bit pointers.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int c_AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;

    // Push and pop on an empty FIFO is a bypass: the entry never gets stored.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && !(pop && empty);
    assign head      = empty ? push_data : r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Fetch front end: PC, ROM issue with credits, prefetch FIFO,
//               branch redirect, halt and restart.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = c_PC_W,
    parameter int INSTR_W = c_INSTR_W,
    parameter int DEPTH   = 4
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               start,
    output logic               rom_en,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               br_req,
    input  logic [PC_W-1:0]    br_target,
    input  logic               halt_req,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               halted,
    output logic [15:0]        fetch_ct
);

    fetch_state_t              r_state;
    logic [PC_W-1:0]           r_fetch_pc;
    logic [PC_W-1:0]           r_inflight_pc;
    logic                      r_inflight;
    logic                      r_inflight_epoch;
    logic                      r_epoch;
    logic [15:0]               r_fetch_ct;

    logic                      w_run;
    logic                      w_halt;
    logic                      w_redirect;
    logic                      w_flush;
    logic                      w_resp;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_valid;
    logic                      w_issue;
    logic                      w_full;
    logic                      w_empty;
    logic [$clog2(DEPTH):0]    w_count;
    fetch_entry_t              w_push_entry;
    fetch_entry_t              w_head;

    assign w_run      = (r_state == RUN);
    assign w_halt     = w_run && !start && halt_req;
    assign w_redirect = w_run && !start && !halt_req && br_req;
    assign w_flush    = start || w_halt || w_redirect;

    // A response whose epoch no longer matches was issued before a flush.
    assign w_resp  = w_run && r_inflight && (r_inflight_epoch == r_epoch);
    assign w_push  = w_resp && !w_flush;
    assign w_valid = w_run && (!w_empty || w_resp);
    assign w_pop   = w_valid && instr_ready && !w_flush;
    assign w_issue = w_run && ((int'(w_count) + int'(r_inflight)) < DEPTH);

    assign w_push_entry = '{pc: r_inflight_pc, instr: rom_data};

    fetch_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (w_flush),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count),
        .head      (w_head)
    );

    assign rom_en      = w_issue;
    assign rom_addr    = w_issue ? r_fetch_pc : '0;
    assign instr_valid = w_valid;
    assign instr_out   = w_valid ? w_head.instr : '0;
    assign instr_pc    = w_valid ? w_head.pc : '0;
    assign halted      = (r_state == HALTED);
    assign fetch_ct    = r_fetch_ct;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_fetch_pc       <= '0;
            r_inflight_pc    <= '0;
            r_inflight       <= 1'b0;
            r_inflight_epoch <= 1'b0;
            r_epoch          <= 1'b0;
            r_fetch_ct       <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc    <= r_fetch_pc;
                r_inflight_epoch <= r_epoch;
            end
            if (w_flush) r_epoch <= ~r_epoch;

            if (start) begin
                r_state    <= RUN;
                r_fetch_pc <= '0;
            end else if (w_halt) begin
                r_state    <= HALTED;
            end else if (w_redirect) begin
                r_fetch_pc <= br_target;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 1'b1;
            end

            if (start)
                r_fetch_ct <= '0;
            else if (w_pop && (r_fetch_ct != 16'hFFFF))
                r_fetch_ct <= r_fetch_ct + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset_n && w_push && !w_pop) assert (!w_full);
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard testbench for fetch_unit with a 1-cycle ROM model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        br_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        instr_ready = 1'b0;
    logic [15:0] br_target = '0;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [8:0]  rom_data = '0;
    logic        instr_valid;
    logic [8:0]  instr_out;
    logic [15:0] instr_pc;
    logic        halted;
    logic [15:0] fetch_ct;

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] exp_q [$];

    always #5 CLK = ~CLK;

    function automatic logic [8:0] rom_word(input logic [15:0] a);
        rom_word = a[8:0] + 9'h100;
    endfunction

    always @(posedge CLK) if (rom_en) rom_data <= rom_word(rom_addr);

    fetch_unit #(.PC_W(16), .INSTR_W(9), .DEPTH(4)) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .start       (start),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .br_req      (br_req),
        .br_target   (br_target),
        .halt_req    (halt_req),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .halted      (halted),
        .fetch_ct    (fetch_ct)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pops the scoreboard on every accepted handshake within the cycle budget.
    task automatic drain(input string tag, input int n, input int budget);
        int          got;
        int          cyc;
        logic [15:0] e;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge CLK);
            if (instr_valid && instr_ready) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s_unexpected: pc=%h, want no delivery", tag, instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (instr_pc !== e || instr_out !== rom_word(e))
                        $display("FAIL %s_data: pc=%h instr=%h, want pc=%h instr=%h",
                                 tag, instr_pc, instr_out, e, rom_word(e));
                    else
                        n_pass++;
                    got++;
                end
            end
            cyc++;
            tick();
        end
        n_total++;
        if (got != n) $display("FAIL %s_count: got %0d deliveries, want %0d", tag, got, n);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        n_total++;
        if ({rom_en, rom_addr, instr_valid, instr_out, instr_pc, halted, fetch_ct} !== '0)
            $display("FAIL reset_outputs: en=%0b addr=%h v=%0b out=%h pc=%h h=%0b ct=%0d, want all 0",
                     rom_en, rom_addr, instr_valid, instr_out, instr_pc, halted, fetch_ct);
        else n_pass++;
        tick();
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            n_total++;
            if (rom_en !== 1'b0 || instr_valid !== 1'b0)
                $display("FAIL idle_quiet: rom_en=%0b valid=%0b, want 0/0", rom_en, instr_valid);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_stream();
        start = 1'b1;
        instr_ready = 1'b1;
        @(negedge CLK);
        n_total++;
        if (rom_en !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL stream_c0: rom_en=%0b valid=%0b, want 0/0", rom_en, instr_valid);
        else n_pass++;
        tick();
        start = 1'b0;
        @(negedge CLK);
        n_total++;
        if (rom_en !== 1'b1 || rom_addr !== 16'h0000 || instr_valid !== 1'b0)
            $display("FAIL stream_c1: rom_en=%0b addr=%h valid=%0b, want 1/0000/0",
                     rom_en, rom_addr, instr_valid);
        else n_pass++;
        tick();
        for (int i = 0; i < 10; i++) exp_q.push_back(16'(i));
        drain("stream", 10, 10);
        instr_ready = 1'b0;
        @(negedge CLK);
        n_total++;
        if (fetch_ct !== 16'd10) $display("FAIL stream_ct: fetch_ct=%0d, want 10", fetch_ct);
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        int n_iss;
        int n_bad;
        start = 1'b1;
        instr_ready = 1'b0;
        tick();
        start = 1'b0;
        n_iss = 0;
        n_bad = 0;
        repeat (10) begin
            @(negedge CLK);
            if (rom_en) begin
                if (rom_addr !== 16'(n_iss)) n_bad++;
                n_iss++;
            end
            tick();
        end
        n_total++;
        if (n_iss != 4 || n_bad != 0)
            $display("FAIL bp_issues: issues=%0d bad_addr=%0d, want 4/0", n_iss, n_bad);
        else n_pass++;
        @(negedge CLK);
        n_total++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || rom_en !== 1'b0)
            $display("FAIL bp_hold: valid=%0b pc=%h rom_en=%0b, want 1/0000/0",
                     instr_valid, instr_pc, rom_en);
        else n_pass++;
        tick();
        for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));
        instr_ready = 1'b1;
        drain("bp", 8, 8);
        instr_ready = 1'b0;
    endtask

    task automatic test_branch();
        start = 1'b1;
        instr_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) exp_q.push_back(16'(i));
        drain("br_pre", 5, 5);
        instr_ready = 1'b0;
        repeat (3) tick();
        br_req = 1'b1;
        br_target = 16'h0040;
        @(negedge CLK);
        n_total++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0005)
            $display("FAIL br_head: valid=%0b pc=%h, want 1/0005", instr_valid, instr_pc);
        else n_pass++;
        tick();
        br_req = 1'b0;
        instr_ready = 1'b1;
        @(negedge CLK);
        n_total++;
        if (instr_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 16'h0040)
            $display("FAIL br_redirect: valid=%0b rom_en=%0b addr=%h, want 0/1/0040",
                     instr_valid, rom_en, rom_addr);
        else n_pass++;
        tick();
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h0040 + 16'(i));
        drain("br_post", 4, 4);
        instr_ready = 1'b0;
    endtask

    task automatic test_halt();
        start = 1'b1;
        instr_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) exp_q.push_back(16'(i));
        drain("halt_pre", 3, 3);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        @(negedge CLK);
        n_total++;
        if (halted !== 1'b1 || rom_en !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL halt_enter: halted=%0b rom_en=%0b valid=%0b, want 1/0/0",
                     halted, rom_en, instr_valid);
        else n_pass++;
        repeat (2) tick();
        @(negedge CLK);
        n_total++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || rom_en !== 1'b0 || fetch_ct !== 16'd3)
            $display("FAIL halt_stay: halted=%0b valid=%0b rom_en=%0b ct=%0d, want 1/0/0/3",
                     halted, instr_valid, rom_en, fetch_ct);
        else n_pass++;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge CLK);
        n_total++;
        if (halted !== 1'b0 || fetch_ct !== 16'd0 || rom_en !== 1'b1 || rom_addr !== 16'h0000)
            $display("FAIL halt_restart: halted=%0b ct=%0d rom_en=%0b addr=%h, want 0/0/1/0000",
                     halted, fetch_ct, rom_en, rom_addr);
        else n_pass++;
        tick();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        drain("halt_post", 2, 2);
        instr_ready = 1'b0;
    endtask

    task automatic test_halt_branch();
        int n_bad;
        start = 1'b1;
        instr_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        drain("hb_pre", 2, 2);
        halt_req = 1'b1;
        br_req = 1'b1;
        br_target = 16'h0080;
        tick();
        halt_req = 1'b0;
        br_req = 1'b0;
        n_bad = 0;
        repeat (4) begin
            @(negedge CLK);
            if (rom_en || instr_valid || !halted) n_bad++;
            tick();
        end
        n_total++;
        if (n_bad != 0) $display("FAIL hb_halted: %0d bad cycles, want 0", n_bad);
        else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge CLK);
        n_total++;
        if (rom_en !== 1'b1 || rom_addr !== 16'h0000)
            $display("FAIL hb_restart: rom_en=%0b addr=%h, want 1/0000", rom_en, rom_addr);
        else n_pass++;
        tick();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        drain("hb_post", 2, 2);
        instr_ready = 1'b0;
    endtask

    task automatic test_wrap_reset();
        start = 1'b1;
        instr_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) exp_q.push_back(16'(i));
        drain("wrap_pre", 3, 3);
        br_req = 1'b1;
        br_target = 16'hFFFF;
        tick();
        br_req = 1'b0;
        @(negedge CLK);
        n_total++;
        if (instr_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 16'hFFFF)
            $display("FAIL wrap_stale: valid=%0b pc=%h rom_en=%0b addr=%h, want 0/-/1/ffff",
                     instr_valid, instr_pc, rom_en, rom_addr);
        else n_pass++;
        tick();
        exp_q.push_back(16'hFFFF);
        for (int i = 0; i < 3; i++) exp_q.push_back(16'(i));
        drain("wrap", 4, 4);
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({rom_en, rom_addr, instr_valid, instr_out, instr_pc, halted, fetch_ct} !== '0)
            $display("FAIL async_reset: en=%0b addr=%h v=%0b out=%h pc=%h h=%0b ct=%0d, want all 0",
                     rom_en, rom_addr, instr_valid, instr_out, instr_pc, halted, fetch_ct);
        else n_pass++;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            n_total++;
            if (rom_en !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0)
                $display("FAIL post_reset_idle: rom_en=%0b valid=%0b halted=%0b, want 0/0/0",
                         rom_en, instr_valid, halted);
            else n_pass++;
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        drain("wrap_post", 2, 2);
        instr_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_halt();
        test_halt_branch();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d at timeout", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
